// File: rtl/riscv_pkg.sv
// ============================================================================
// Module : riscv_pkg
// Brief  : Shared core types and constants used by the fetch sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam int ALEN        = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [ALEN-1:0] RESET_VECTOR = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

    function automatic logic is_aligned(input logic [ALEN-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

`default_nettype wire

// File: rtl/imem_fetch_ctrl.sv
// ============================================================================
// Module : imem_fetch_ctrl
// Brief  : Fetch sequencer driving a 1-cycle synchronous instruction ROM and
//          presenting PC/instruction pairs to decode over valid/ready.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module imem_fetch_ctrl
    import riscv_pkg::*;
#(
    parameter logic [ALEN-1:0] RESET_PC = RESET_VECTOR,
    parameter int              CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,

    output logic             imem_en,
    output logic [ALEN-1:0]  imem_addr,
    input  logic [31:0]      imem_rdata,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [ALEN-1:0]  out_pc,
    output logic [31:0]      out_instr,

    input  logic             redirect_valid,
    input  logic [ALEN-1:0]  redirect_pc,
    input  logic             halt_req,

    output logic             halted,
    output logic             fetch_fault,
    output logic [ALEN-1:0]  fault_pc,
    output logic [CNT_W-1:0] fetch_count
);

    fetch_state_t     state_q,       state_d;
    logic [ALEN-1:0]  fetch_pc_q,    fetch_pc_d;
    logic             out_valid_q,   out_valid_d;
    logic [ALEN-1:0]  out_pc_q,      out_pc_d;
    logic [ALEN-1:0]  fault_pc_q,    fault_pc_d;
    logic [CNT_W-1:0] fetch_count_q, fetch_count_d;

    logic en_w;
    logic use_redir_w;
    logic redir_ok_w;
    logic redir_bad_w;
    logic handshake_w;
    logic issue_w;

    assign redir_ok_w  = redirect_valid &&  is_aligned(redirect_pc);
    assign redir_bad_w = redirect_valid && !is_aligned(redirect_pc);
    assign handshake_w = out_valid_q && out_ready;
    assign issue_w     = !out_valid_q || out_ready;

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        out_valid_d   = out_valid_q;
        out_pc_d      = out_pc_q;
        fault_pc_d    = fault_pc_q;
        fetch_count_d = fetch_count_q;
        en_w          = 1'b0;
        use_redir_w   = 1'b0;

        case (state_q)
            BOOT: begin
                if (redir_ok_w) begin
                    fetch_pc_d = redirect_pc;
                end
                state_d = RUN;
            end

            RUN, HALT: begin
                if (redir_bad_w) begin
                    state_d     = FAULT;
                    fault_pc_d  = redirect_pc;
                    out_valid_d = 1'b0;
                end else if (redir_ok_w) begin
                    // The presented entry is flushed, so it is never counted.
                    en_w        = 1'b1;
                    use_redir_w = 1'b1;
                    out_pc_d    = redirect_pc;
                    out_valid_d = 1'b1;
                    fetch_pc_d  = redirect_pc + ALEN'(INSTR_BYTES);
                    state_d     = RUN;
                end else begin
                    if (handshake_w) begin
                        fetch_count_d = fetch_count_q + CNT_W'(1);
                    end
                    if ((state_q == RUN) && !halt_req) begin
                        if (issue_w) begin
                            en_w        = 1'b1;
                            out_pc_d    = fetch_pc_q;
                            out_valid_d = 1'b1;
                            fetch_pc_d  = fetch_pc_q + ALEN'(INSTR_BYTES);
                        end
                    end else begin
                        state_d     = HALT;
                        out_valid_d = out_valid_q && !out_ready;
                    end
                end
            end

            default: begin
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= BOOT;
            fetch_pc_q    <= RESET_PC;
            out_valid_q   <= 1'b0;
            out_pc_q      <= '0;
            fault_pc_q    <= '0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            out_valid_q   <= out_valid_d;
            out_pc_q      <= out_pc_d;
            fault_pc_q    <= fault_pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // Reset gates the enable combinationally so the ROM stops at once.
    assign imem_en     = en_w && !rst;
    assign imem_addr   = use_redir_w ? redirect_pc : fetch_pc_q;

    assign out_valid   = out_valid_q;
    assign out_pc      = out_pc_q;
    assign out_instr   = imem_rdata;
    assign halted      = (state_q == HALT);
    assign fetch_fault = (state_q == FAULT);
    assign fault_pc    = fault_pc_q;
    assign fetch_count = fetch_count_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
// ============================================================================
// Module : tb_imem_fetch_ctrl
// Brief  : Scoreboard bench for imem_fetch_ctrl with a transaction-level model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_imem_fetch_ctrl;
    import riscv_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        halted;
    logic        fetch_fault;
    logic [31:0] fault_pc;
    logic [31:0] fetch_count;

    always #5 clk = ~clk;

    imem_fetch_ctrl #(.RESET_PC(RST_PC), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_instr(out_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt_req(halt_req),
        .halted(halted), .fetch_fault(fetch_fault), .fault_pc(fault_pc),
        .fetch_count(fetch_count)
    );

    // Synchronous ROM: 64 words, address wraps modulo 256 bytes.
    logic [31:0] rom [0:63];
    always @(posedge clk) if (imem_en) imem_rdata <= rom[imem_addr[7:2]];

    int checks   = 0;
    int failures = 0;
    bit done     = 1'b0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } txn_t;
    txn_t sb[$];

    // Model: mode 0=boot 1=run 2=halt 3=fault; one entry slot toward decode.
    int          m_mode;
    bit          m_hold;
    logic [31:0] m_hpc;
    logic [31:0] m_npc;
    logic [31:0] m_fpc;
    logic [31:0] m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic hs;
        txn_t t;
        if (!rst && !done) begin
            hs = out_valid && out_ready && !redirect_valid;
            chk1("handshake_expected", hs, sb.size() != 0);
            if (hs && sb.size() != 0) begin
                t = sb.pop_front();
                chk("deliver_pc", out_pc, t.pc);
                chk("deliver_instr", out_instr, t.instr);
            end else if (sb.size() != 0) begin
                sb.delete();
            end
        end
    end

    task automatic model_reset();
        m_mode = 0;
        m_hold = 1'b0;
        m_hpc  = '0;
        m_npc  = RST_PC;
        m_fpc  = '0;
        m_cnt  = '0;
        sb.delete();
    endtask

    // Called at posedge+2; returns at the next posedge+2.
    task automatic cycle(input bit rv, input logic [31:0] rpc, input bit hr, input bit rdy);
        bit          exp_en;
        logic [31:0] exp_addr;
        txn_t        t;
        redirect_valid = rv;
        redirect_pc    = rpc;
        halt_req       = hr;
        out_ready      = rdy;
        #1;
        chk1("out_valid", out_valid, m_hold);
        if (m_hold) chk("out_pc", out_pc, m_hpc);
        chk1("halted", halted, m_mode == 2);
        chk1("fetch_fault", fetch_fault, m_mode == 3);
        if (m_mode == 3) chk("fault_pc", fault_pc, m_fpc);
        chk("fetch_count", fetch_count, m_cnt);

        exp_en   = 1'b0;
        exp_addr = m_npc;
        if (m_mode == 1 || m_mode == 2) begin
            if (rv && rpc[1:0] == 2'b00) begin
                exp_en   = 1'b1;
                exp_addr = rpc;
            end else if (!rv && m_mode == 1 && !hr && (!m_hold || rdy)) begin
                exp_en = 1'b1;
            end
        end
        chk1("imem_en", imem_en, exp_en);
        chk("imem_addr", imem_addr, exp_addr);

        case (m_mode)
            0: begin
                if (rv && rpc[1:0] == 2'b00) m_npc = rpc;
                m_mode = 1;
            end
            1, 2: begin
                if (rv && rpc[1:0] != 2'b00) begin
                    m_mode = 3;
                    m_fpc  = rpc;
                    m_hold = 1'b0;
                end else if (rv) begin
                    m_hold = 1'b1;
                    m_hpc  = rpc;
                    m_npc  = rpc + 32'd4;
                    m_mode = 1;
                end else begin
                    if (m_hold && rdy) begin
                        t.pc    = m_hpc;
                        t.instr = rom[m_hpc[7:2]];
                        sb.push_back(t);
                        m_cnt  = m_cnt + 32'd1;
                        m_hold = 1'b0;
                    end
                    if (m_mode == 1 && hr) begin
                        m_mode = 2;
                    end else if (m_mode == 1 && !m_hold) begin
                        m_hold = 1'b1;
                        m_hpc  = m_npc;
                        m_npc  = m_npc + 32'd4;
                    end
                end
            end
            default: ;
        endcase
        @(posedge clk);
        #2;
    endtask

    // Asserted between edges; outputs must clear without waiting for a clock.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_imem_en", imem_en, 1'b0);
        chk("rst_fetch_count", fetch_count, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_fault_pc", fault_pc, 32'h0);
        chk1("rst_halted", halted, 1'b0);
        chk1("rst_fault", fetch_fault, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [31:0] rpc;
        bit          rv;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halt_req       = 1'b0;
        out_ready      = 1'b0;
        for (int i = 0; i < 64; i++) rom[i] = $urandom;
        rom[0] = 32'hDEADBEEF;
        rom[1] = 32'hCAFEBABE;
        rom[2] = 32'h00000013;
        rom[3] = 32'h00100093;
        model_reset();
        @(posedge clk);
        #2;
        do_reset();

        // Sequential fetch, then backpressure while holding PC 4.
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        repeat (3) cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);
        // Redirect while stalled on PC C.
        cycle(1, 32'h4, 0, 0);
        cycle(0, 0, 0, 1);
        // Halt with PC 8 held, drain, then resume via redirect.
        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        cycle(1, 32'h0, 0, 1);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        // Misaligned target, then attempts to leave the fault.
        cycle(1, 32'h6, 0, 0);
        cycle(1, 32'h8, 0, 1);
        cycle(0, 0, 1, 1);
        cycle(0, 0, 0, 1);
        do_reset();
        // Reset in the middle of a stall.
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        do_reset();
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);

        for (int n = 0; n < 3000; n++) begin
            if (m_mode == 3 && ($urandom % 8) == 0) begin
                do_reset();
            end else begin
                rv  = (($urandom % 10) == 0);
                rpc = 32'($urandom_range(0, 63)) << 2;
                if (($urandom % 10) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
                cycle(rv, rpc, ($urandom % 16) == 0, ($urandom % 4) != 0);
            end
        end

        cycle(0, 0, 0, 1);
        chk("scoreboard_empty", 32'(sb.size()), 32'h0);
        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
